// File: rtl/rob_wb_arbiter_pkg.sv
// Shared types and constants for the ROB write-back arbiter.
// Carries the ROB entry payload type and the requester index assignments.
package rob_wb_arbiter_pkg;

  typedef struct packed {
    logic [31:0] value;
    logic        exc;
    logic [4:0]  cause;
  } rob_entry_t;

  localparam int WB_REQ_BRANCH = 0;
  localparam int WB_REQ_LS     = 1;
  localparam int WB_REQ_EX1    = 2;
  localparam int WB_REQ_EXMUL1 = 3;

  localparam int WB_NREQ_DEFAULT   = 4;
  localparam int WB_NPORTS_DEFAULT = 2;
  localparam int WB_SLOT_W_DEFAULT = 4;

  // Index width that stays at least one bit wide for single-entry rings.
  function automatic int wb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_wb_arbiter_rr_picker.sv
// Round-robin picker: walks the holding-register ring from rr_ptr and grants the
// first NPORTS occupied entries, numbering them in the order they were found.
module rob_wb_rr_picker
  import rob_wb_arbiter_pkg::*;
#(
  parameter int NREQ   = WB_NREQ_DEFAULT,
  parameter int NPORTS = WB_NPORTS_DEFAULT,
  parameter int PTR_W  = wb_idx_w(NREQ),
  parameter int PORT_W = wb_idx_w(NPORTS)
) (
  input  logic              en,
  input  logic [NREQ-1:0]   held_v,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NREQ-1:0]   grant,
  output logic [PORT_W-1:0] grant_port [NREQ],
  output logic [PTR_W-1:0]  next_ptr
);

  localparam int               CNT_W      = $clog2(NPORTS + 1);
  localparam logic [CNT_W-1:0] PORT_LIMIT = CNT_W'(NPORTS);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NREQ - 1);

  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    grant    = '0;
    next_ptr = rr_ptr;
    idx      = rr_ptr;
    cnt      = '0;
    for (int i = 0; i < NREQ; i++) grant_port[i] = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (en && held_v[idx] && (cnt < PORT_LIMIT)) begin
        grant[idx]      = 1'b1;
        grant_port[idx] = cnt[PORT_W-1:0];
        cnt             = cnt + CNT_W'(1);
        // Pointer lands just past the most recent grant so it goes last next time.
        next_ptr        = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
      end
      idx = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// ROB write-back arbiter: one holding register per producer, round-robin onto NPORTS
// ROB write ports. Define ROB_WB_ARB_PERF_EN to add conflict/stall performance counters.
module rob_wb_arbiter
  import rob_wb_arbiter_pkg::*;
#(
  parameter int NREQ   = WB_NREQ_DEFAULT,
  parameter int NPORTS = WB_NPORTS_DEFAULT,
  parameter int SLOT_W = WB_SLOT_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [SLOT_W-1:0] req_slot [NREQ],
  input  rob_entry_t        req_data [NREQ],
  output logic [NREQ-1:0]   req_ready,
  output logic [NPORTS-1:0] wr_valid,
  output logic [SLOT_W-1:0] wr_slot [NPORTS],
  output rob_entry_t        wr_data [NPORTS],
  input  logic              rob_wr_stall,
  input  logic              flush
`ifdef ROB_WB_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int PTR_W  = wb_idx_w(NREQ);
  localparam int PORT_W = wb_idx_w(NPORTS);

  logic [NREQ-1:0]   held_v_q, held_v_d;
  logic [SLOT_W-1:0] held_slot_q [NREQ];
  logic [SLOT_W-1:0] held_slot_d [NREQ];
  rob_entry_t        held_data_q [NREQ];
  rob_entry_t        held_data_d [NREQ];
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0]   grant;
  logic [PORT_W-1:0] grant_port [NREQ];
  logic [NREQ-1:0]   accept;
  logic              pick_en;

  // Flush and stall both suppress every grant, which also keeps rr_ptr still.
  assign pick_en = ~rob_wr_stall & ~flush;

  rob_wb_rr_picker #(
    .NREQ   (NREQ),
    .NPORTS (NPORTS),
    .PTR_W  (PTR_W),
    .PORT_W (PORT_W)
  ) u_picker (
    .en         (pick_en),
    .held_v     (held_v_q),
    .rr_ptr     (rr_ptr_q),
    .grant      (grant),
    .grant_port (grant_port),
    .next_ptr   (rr_ptr_d)
  );

  assign req_ready = flush ? '0 : (~held_v_q | grant);
  assign accept    = req_valid & req_ready;

  always_comb begin
    held_v_d    = held_v_q;
    held_slot_d = held_slot_q;
    held_data_d = held_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (flush) begin
        held_v_d[i] = 1'b0;
      end else if (accept[i]) begin
        held_v_d[i]    = 1'b1;
        held_slot_d[i] = req_slot[i];
        held_data_d[i] = req_data[i];
      end else if (grant[i]) begin
        held_v_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      wr_valid[k] = 1'b0;
      wr_slot[k]  = '0;
      wr_data[k]  = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && (grant_port[i] == PORT_W'(k))) begin
          wr_valid[k] = 1'b1;
          wr_slot[k]  = held_slot_q[i];
          wr_data[k]  = held_data_q[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_v_q <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        held_slot_q[i] <= '0;
        held_data_q[i] <= '0;
      end
    end else begin
      held_v_q    <= held_v_d;
      rr_ptr_q    <= rr_ptr_d;
      held_slot_q <= held_slot_d;
      held_data_q <= held_data_d;
    end
  end

  // Two live results aimed at the same ROB slot means a producer is broken.
  logic slot_conflict;
  always_comb begin
    slot_conflict = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (held_v_q[i] && held_v_q[j] && (held_slot_q[i] == held_slot_q[j]))
          slot_conflict = 1'b1;
      end
    end
  end

  a_no_slot_conflict: assert property (@(posedge clock) disable iff (!reset_n) !slot_conflict);

`ifdef ROB_WB_ARB_PERF_EN
  localparam int              HC_W       = $clog2(NREQ + 1);
  localparam logic [HC_W-1:0] PORTS_HELD = HC_W'(NPORTS);

  logic [HC_W-1:0] held_cnt;
  logic [31:0]     perf_conflict_q, perf_conflict_d;
  logic [31:0]     perf_stall_q, perf_stall_d;

  always_comb begin
    held_cnt = '0;
    for (int i = 0; i < NREQ; i++) held_cnt = held_cnt + HC_W'(held_v_q[i]);
    perf_conflict_d = perf_conflict_q;
    perf_stall_d    = perf_stall_q;
    if (!rob_wr_stall && (held_cnt > PORTS_HELD) && (perf_conflict_q != '1))
      perf_conflict_d = perf_conflict_q + 32'd1;
    if (rob_wr_stall && (|held_v_q) && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_conflict_cycles = perf_conflict_q;
  assign perf_stall_cycles    = perf_stall_q;
`endif

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Scoreboard bench for rob_wb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the holding registers and round-robin grant order.
module tb_rob_wb_arbiter;
  import rob_wb_arbiter_pkg::*;

  localparam int NREQ   = 4;
  localparam int NPORTS = 2;
  localparam int SLOT_W = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [SLOT_W-1:0] req_slot [NREQ];
  rob_entry_t        req_data [NREQ];
  logic [NREQ-1:0]   req_ready;
  logic [NPORTS-1:0] wr_valid;
  logic [SLOT_W-1:0] wr_slot [NPORTS];
  rob_entry_t        wr_data [NPORTS];
  logic              rob_wr_stall = 1'b0;
  logic              flush = 1'b0;
`ifdef ROB_WB_ARB_PERF_EN
  logic [31:0]       perf_conflict_cycles;
  logic [31:0]       perf_stall_cycles;
`endif

  always #5 clock = ~clock;

  rob_wb_arbiter #(.NREQ(NREQ), .NPORTS(NPORTS), .SLOT_W(SLOT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_slot     (req_slot),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_valid     (wr_valid),
    .wr_slot      (wr_slot),
    .wr_data      (wr_data),
    .rob_wr_stall (rob_wr_stall),
    .flush        (flush)
`ifdef ROB_WB_ARB_PERF_EN
    ,
    .perf_conflict_cycles (perf_conflict_cycles),
    .perf_stall_cycles    (perf_stall_cycles)
`endif
  );

  typedef struct {
    int                port;
    logic [SLOT_W-1:0] slot;
    rob_entry_t        data;
  } wr_exp_t;

  wr_exp_t         wr_q[$];
  logic [NREQ-1:0] rdy_q[$];
  int              checks = 0;
  int              errors = 0;
  bit              mon_en = 1'b0;

  // Reference model state: what each producer's holding register contains.
  bit                m_v [NREQ];
  logic [SLOT_W-1:0] m_slot [NREQ];
  rob_entry_t        m_data [NREQ];
  int                m_rr;
  longint            m_conf;
  longint            m_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic rob_entry_t rand_data();
    rob_entry_t d;
    d.value = $urandom;
    d.exc   = 1'($urandom_range(0, 1));
    d.cause = 5'($urandom_range(0, 31));
    return d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREQ; i++) begin
      m_v[i]    = 1'b0;
      m_slot[i] = '0;
      m_data[i] = '0;
    end
    m_rr    = 0;
    m_conf  = 0;
    m_stall = 0;
  endtask

  // Apply the current req_* inputs for one cycle, predicting that cycle's outputs.
  task automatic drive(input logic stall, input logic fl);
    bit              g [NREQ];
    int              cnt;
    int              last;
    int              held_n;
    logic [NREQ-1:0] rdy;
    rob_wr_stall = stall;
    flush        = fl;
    mon_en       = 1'b1;
    cnt    = 0;
    last   = -1;
    held_n = 0;
    for (int i = 0; i < NREQ; i++) begin
      g[i]   = 1'b0;
      held_n = held_n + (m_v[i] ? 1 : 0);
    end
    if (stall && held_n > 0) m_stall++;
    if (!stall && held_n > NPORTS) m_conf++;
    if (!stall && !fl) begin
      for (int j = 0; j < NREQ; j++) begin
        int r;
        r = (m_rr + j) % NREQ;
        if (m_v[r] && cnt < NPORTS) begin
          wr_exp_t e;
          e.port = cnt;
          e.slot = m_slot[r];
          e.data = m_data[r];
          wr_q.push_back(e);
          g[r] = 1'b1;
          cnt++;
          last = r;
        end
      end
    end
    if (last >= 0) m_rr = (last + 1) % NREQ;
    for (int i = 0; i < NREQ; i++) rdy[i] = !fl && (!m_v[i] || g[i]);
    rdy_q.push_back(rdy);
    for (int i = 0; i < NREQ; i++) begin
      if (fl) begin
        m_v[i] = 1'b0;
      end else if (req_valid[i] && rdy[i]) begin
        m_v[i]    = 1'b1;
        m_slot[i] = req_slot[i];
        m_data[i] = req_data[i];
      end else if (g[i]) begin
        m_v[i] = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_perf();
`ifdef ROB_WB_ARB_PERF_EN
    chk("perf_conflict", 64'(perf_conflict_cycles), 64'(m_conf));
    chk("perf_stall", 64'(perf_stall_cycles), 64'(m_stall));
`endif
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    chk("queue_drained", 64'(wr_q.size()), 64'd0);
    check_perf();
    req_valid    = '0;
    rob_wr_stall = 1'b0;
    flush        = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_clear();
    wr_q.delete();
    rdy_q.delete();
    chk("reset_wr_valid", 64'(wr_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'hf);
    check_perf();
  endtask

  function automatic logic [SLOT_W-1:0] pick_slot(input int i);
    int start;
    start = $urandom_range(0, (1 << SLOT_W) - 1);
    for (int t = 0; t < (1 << SLOT_W); t++) begin
      logic [SLOT_W-1:0] s;
      bit                used;
      s    = SLOT_W'((start + t) % (1 << SLOT_W));
      used = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
        if (j != i && m_v[j] && m_slot[j] == s) used = 1'b1;
        if (j < i && req_valid[j] && req_slot[j] == s) used = 1'b1;
      end
      if (!used) return s;
    end
    return '0;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (rdy_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ready_expect actual=none required=entry");
        end else begin
          chk("req_ready", 64'(req_ready), 64'(rdy_q.pop_front()));
        end
        for (int k = 0; k < NPORTS; k++) begin
          if (wr_valid[k]) begin
            if (wr_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write actual=port%0d required=none", k);
            end else begin
              wr_exp_t e;
              e = wr_q.pop_front();
              chk("wr_port", 64'(k), 64'(e.port));
              chk("wr_slot", 64'(wr_slot[k]), 64'(e.slot));
              chk("wr_data", 64'(wr_data[k]), 64'(e.data));
              $display("t=%0t wr port=%0d slot=%0d value=%08h", $time, k, wr_slot[k], wr_data[k].value);
            end
          end else begin
            chk("idle_slot", 64'(wr_slot[k]), 64'd0);
            chk("idle_data", 64'(wr_data[k]), 64'd0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < NREQ; i++) begin
      req_slot[i] = '0;
      req_data[i] = '0;
    end
    model_clear();
    #2;
    chk("async_reset_wr_valid0", 64'(wr_valid), 64'd0);
    do_reset();

    // Single LS result
    req_valid = 4'b0010;
    req_slot[WB_REQ_LS] = 4'd5;
    req_data[WB_REQ_LS] = rand_data();
    drive(1'b0, 1'b0);
    req_valid = '0;
    repeat (2) drive(1'b0, 1'b0);

    // Oversubscription from rr_ptr = 0
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_slot[i] = SLOT_W'(i + 1);
      req_data[i] = rand_data();
    end
    drive(1'b0, 1'b0);
    req_valid = '0;
    repeat (3) drive(1'b0, 1'b0);

    // EX1 back-to-back refill
    for (int s = 0; s < 4; s++) begin
      req_valid = 4'b0100;
      req_slot[WB_REQ_EX1] = SLOT_W'(s);
      req_data[WB_REQ_EX1] = rand_data();
      drive(1'b0, 1'b0);
    end
    req_valid = '0;
    repeat (2) drive(1'b0, 1'b0);

    // ROB stall holding slots 7 and 9 for three cycles
    do_reset();
    req_valid = 4'b0011;
    req_slot[0] = 4'd7;
    req_slot[1] = 4'd9;
    req_data[0] = rand_data();
    req_data[1] = rand_data();
    drive(1'b0, 1'b0);
    req_valid = '0;
    repeat (3) drive(1'b1, 1'b0);
    check_perf();
    repeat (2) drive(1'b0, 1'b0);

    // Flush with a new request offered in the same cycle
    req_valid = 4'b0101;
    req_slot[0] = 4'd10;
    req_slot[2] = 4'd11;
    req_data[0] = rand_data();
    req_data[2] = rand_data();
    drive(1'b1, 1'b0);
    req_valid = 4'b0010;
    req_slot[1] = 4'd12;
    req_data[1] = rand_data();
    drive(1'b0, 1'b1);
    req_valid = '0;
    repeat (2) drive(1'b0, 1'b0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 55);
        req_slot[i]  = pick_slot(i);
        req_data[i]  = rand_data();
      end
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3);
    end
    req_valid = '0;
    repeat (4) drive(1'b0, 1'b0);

    // Asynchronous reset while grants are being presented
    do_reset();
    req_valid = 4'b0101;
    req_slot[0] = 4'd3;
    req_slot[2] = 4'd8;
    req_data[0] = rand_data();
    req_data[2] = rand_data();
    drive(1'b1, 1'b0);
    mon_en       = 1'b0;
    req_valid    = '0;
    rob_wr_stall = 1'b0;
    #1;
    chk("pre_reset_wr_valid", 64'(wr_valid), 64'h3);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_wr_valid", 64'(wr_valid), 64'd0);
    chk("mid_reset_req_ready", 64'(req_ready), 64'hf);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_clear();
    wr_q.delete();
    rdy_q.delete();
    repeat (3) drive(1'b0, 1'b0);
    req_valid = 4'b1000;
    req_slot[3] = 4'd6;
    req_data[3] = rand_data();
    drive(1'b0, 1'b0);
    req_valid = '0;
    repeat (2) drive(1'b0, 1'b0);

    mon_en = 1'b0;
    chk("final_queue_drained", 64'(wr_q.size()), 64'd0);
    check_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
